// File: rtl/lfsr16_checker.sv
// Receive-side checker for the lfsr16 PRNG stream: seeds a shadow LFSR from the
// received bits, then predicts each bit and tracks mismatches and lock status.
module lfsr16_checker #(
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int WERR_W = $clog2(WINDOW + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] THRESH   = WERR_W'(LOSS_THRESH);

    typedef enum logic {SEED, CHECK} state_t;

    state_t             r_state;
    logic [15:0]        r_shadow;
    logic [3:0]         r_seedCnt;
    logic [WIN_W-1:0]   r_winCnt;
    logic [WERR_W-1:0]  r_winErr;
    logic               r_locked;
    logic               r_errPulse;
    logic               r_lockLost;
    logic [CNT_W-1:0]   r_errCount;
    logic [CNT_W-1:0]   r_bitCount;

    logic               w_pred;
    logic [15:0]        w_seedNext;
    logic               w_checking;
    logic               w_mismatch;
    logic [WERR_W-1:0]  w_winErrInc;
    logic               w_loss;
    logic [CNT_W-1:0]   w_errNext;
    logic [CNT_W-1:0]   w_bitNext;

    assign w_pred      = ~(r_shadow[15] ^ r_shadow[14] ^ r_shadow[12] ^ r_shadow[3]);
    assign w_seedNext  = {r_shadow[14:0], bit_in};
    assign w_checking  = bit_valid && (r_state == CHECK);
    assign w_mismatch  = w_checking && (bit_in != w_pred);
    assign w_winErrInc = r_winErr + {{(WERR_W-1){1'b0}}, w_mismatch};
    assign w_loss      = w_checking && (w_winErrInc >= THRESH);

    // A clear coinciding with a checked bit restarts the counters from that bit.
    always_comb begin
        w_errNext = clear_cnt ? '0 : r_errCount;
        w_bitNext = clear_cnt ? '0 : r_bitCount;
        if (w_mismatch && !(&w_errNext)) begin
            w_errNext = w_errNext + CNT_W'(1);
        end
        if (w_checking && !(&w_bitNext)) begin
            w_bitNext = w_bitNext + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SEED;
            r_shadow   <= 16'h0000;
            r_seedCnt  <= 4'd0;
            r_winCnt   <= '0;
            r_winErr   <= '0;
            r_locked   <= 1'b0;
            r_errPulse <= 1'b0;
            r_lockLost <= 1'b0;
            r_errCount <= '0;
            r_bitCount <= '0;
        end else begin
            r_errPulse <= 1'b0;
            r_lockLost <= 1'b0;
            r_errCount <= w_errNext;
            r_bitCount <= w_bitNext;
            if (bit_valid) begin
                if (r_state == SEED) begin
                    r_shadow <= w_seedNext;
                    if (r_seedCnt == 4'd15) begin
                        r_seedCnt <= 4'd0;
                        // All-ones is the XNOR lock-up state; keep seeding.
                        if (w_seedNext != 16'hFFFF) begin
                            r_state  <= CHECK;
                            r_locked <= 1'b1;
                            r_winCnt <= '0;
                            r_winErr <= '0;
                        end
                    end else begin
                        r_seedCnt <= r_seedCnt + 4'd1;
                    end
                end else begin
                    r_errPulse <= w_mismatch;
                    if (w_loss) begin
                        r_state    <= SEED;
                        r_locked   <= 1'b0;
                        r_lockLost <= 1'b1;
                        r_seedCnt  <= 4'd0;
                        r_shadow   <= 16'h0000;
                        r_winCnt   <= '0;
                        r_winErr   <= '0;
                    end else begin
                        // Shift in the prediction so a bad bit cannot poison later ones.
                        r_shadow <= {r_shadow[14:0], w_pred};
                        r_winCnt <= r_winCnt + WIN_W'(1);
                        r_winErr <= (r_winCnt == WIN_LAST) ? '0 : w_winErrInc;
                    end
                end
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_errPulse;
    assign lock_lost = r_lockLost;
    assign err_count = r_errCount;
    assign bit_count = r_bitCount;

endmodule

// File: tb/tb_lfsr16_checker.sv
// Self-checking bench for lfsr16_checker: a stream-history model checked every cycle,
// plus literal expectations at key points of each directed scenario.
module tb_lfsr16_checker;

    localparam int WINDOW      = 256;
    localparam int LOSS_THRESH = 8;
    localparam int CNT_W       = 24;
    localparam int CNT_W_SMALL = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic clear_cnt = 1'b0;

    logic                   lockedA, errPulseA, lockLostA;
    logic [CNT_W-1:0]       errCountA, bitCountA;
    logic                   lockedB, errPulseB, lockLostB;
    logic [CNT_W_SMALL-1:0] errCountB, bitCountB;

    lfsr16_checker #(.WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)) dutWide (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear_cnt(clear_cnt), .locked(lockedA), .err_pulse(errPulseA),
        .lock_lost(lockLostA), .err_count(errCountA), .bit_count(bitCountA)
    );

    lfsr16_checker #(.WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W_SMALL)) dutNarrow (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear_cnt(clear_cnt), .locked(lockedB), .err_pulse(errPulseB),
        .lock_lost(lockLostB), .err_count(errCountB), .bit_count(bitCountB)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit chkEn = 1'b0;

    // Model: the expected stream follows the recurrence of the generator's bit history.
    bit mLocked, mErrPulse, mLockLost;
    int mSeedCount, mWinCnt, mWinErr, mErrRaw, mBitRaw;
    bit hist[$];
    logic [15:0] gState;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic logic [31:0] satVal(input int raw, input int w);
        int maxv;
        maxv = (1 << w) - 1;
        return (raw > maxv) ? maxv : raw;
    endfunction

    task automatic modelUpdate(input bit rst, input bit v, input bit b, input bit clr);
        bit expBit;
        bit allOnes;
        if (rst) begin
            mLocked = 0; mErrPulse = 0; mLockLost = 0;
            mSeedCount = 0; mWinCnt = 0; mWinErr = 0; mErrRaw = 0; mBitRaw = 0;
            hist.delete();
            return;
        end
        mErrPulse = 0;
        mLockLost = 0;
        if (clr) begin
            mErrRaw = 0;
            mBitRaw = 0;
        end
        if (!v) return;
        if (!mLocked) begin
            hist.push_back(b);
            mSeedCount++;
            if (mSeedCount == 16) begin
                mSeedCount = 0;
                allOnes = 1;
                foreach (hist[i]) if (!hist[i]) allOnes = 0;
                if (allOnes) hist.delete();
                else begin
                    mLocked = 1;
                    mWinCnt = 0;
                    mWinErr = 0;
                end
            end
        end else begin
            expBit = ~(hist[0] ^ hist[1] ^ hist[3] ^ hist[12]);
            hist.push_back(expBit);
            void'(hist.pop_front());
            mBitRaw++;
            mWinCnt++;
            if (b != expBit) begin
                mErrRaw++;
                mWinErr++;
                mErrPulse = 1;
            end
            if (mWinErr >= LOSS_THRESH) begin
                mLocked = 0;
                mLockLost = 1;
                mSeedCount = 0;
                hist.delete();
            end else if (mWinCnt == WINDOW) begin
                mWinCnt = 0;
                mWinErr = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("locked", lockedA, mLocked);
            checkOutput("err_pulse", errPulseA, mErrPulse);
            checkOutput("lock_lost", lockLostA, mLockLost);
            checkOutput("err_count", errCountA, satVal(mErrRaw, CNT_W));
            checkOutput("bit_count", bitCountA, satVal(mBitRaw, CNT_W));
            checkOutput("err_count_w4", errCountB, satVal(mErrRaw, CNT_W_SMALL));
            checkOutput("bit_count_w4", bitCountB, satVal(mBitRaw, CNT_W_SMALL));
        end
    end

    task automatic applyStimulus(input bit rst, input bit v, input bit b, input bit clr);
        reset = rst;
        bit_valid = v;
        bit_in = b;
        clear_cnt = clr;
        @(posedge clk);
        modelUpdate(rst, v, b, clr);
        #1;
    endtask

    task automatic genBit(output bit b);
        b = ~(gState[15] ^ gState[14] ^ gState[12] ^ gState[3]);
        gState = {gState[14:0], b};
    endtask

    task automatic sendGen(input int n, input bit invert = 1'b0);
        bit b;
        for (int i = 0; i < n; i++) begin
            genBit(b);
            applyStimulus(1'b0, 1'b1, b ^ invert, 1'b0);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        chkEn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lockFresh();
        doReset();
        gState = 16'h0000;
        sendGen(16);
    endtask

    initial begin
        bit b;
        int validCount;

        // Reset state
        doReset();
        checkOutput("reset_locked", lockedA, 0);
        checkOutput("reset_err_pulse", errPulseA, 0);
        checkOutput("reset_lock_lost", lockLostA, 0);
        checkOutput("reset_err_count", errCountA, 0);
        checkOutput("reset_bit_count", bitCountA, 0);

        // Lock from reset, then a long clean run
        gState = 16'h0000;
        sendGen(5);
        checkOutput("gen_state_after5", gState, 32'h001E);
        sendGen(10);
        checkOutput("locked_after15", lockedA, 0);
        sendGen(1);
        checkOutput("locked_after16", lockedA, 1);
        sendGen(1000);
        checkOutput("clean_err_count", errCountA, 0);
        checkOutput("clean_bit_count", bitCountA, 1000);
        checkOutput("clean_bit_count_w4", bitCountB, 15);

        // Single error injection
        sendGen(1, 1'b1);
        checkOutput("single_err_pulse", errPulseA, 1);
        checkOutput("single_err_count", errCountA, 1);
        sendGen(1);
        checkOutput("single_pulse_drop", errPulseA, 0);
        sendGen(30);
        checkOutput("single_err_retained", errCountA, 1);
        checkOutput("single_still_locked", lockedA, 1);

        // Loss of lock after eight consecutive errors, then re-lock
        lockFresh();
        sendGen(7, 1'b1);
        checkOutput("loss_not_yet", lockLostA, 0);
        checkOutput("loss_locked_7", lockedA, 1);
        sendGen(1, 1'b1);
        checkOutput("loss_pulse", lockLostA, 1);
        checkOutput("loss_locked", lockedA, 0);
        checkOutput("loss_err_count", errCountA, 8);
        sendGen(1);
        checkOutput("loss_pulse_drop", lockLostA, 0);
        sendGen(14);
        checkOutput("relock_not_yet", lockedA, 0);
        sendGen(1);
        checkOutput("relock", lockedA, 1);
        sendGen(50);
        checkOutput("relock_err_kept", errCountA, 8);

        // Window boundary: 7 + 7 across a wrap survive, 8th on a window's last bit does not
        lockFresh();
        sendGen(249);
        sendGen(7, 1'b1);
        sendGen(7, 1'b1);
        checkOutput("window_still_locked", lockedA, 1);
        checkOutput("window_err_count", errCountA, 14);
        sendGen(249);
        sendGen(7, 1'b1);
        sendGen(248);
        checkOutput("window3_locked", lockedA, 1);
        sendGen(1, 1'b1);
        checkOutput("window_last_loss", lockLostA, 1);
        checkOutput("window_err_total", errCountA, 22);
        checkOutput("window_err_sat_w4", errCountB, 15);

        // Lock-up guard
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("lockup_no_lock", lockedA, 0);
        gState = 16'h0000;
        sendGen(15);
        checkOutput("lockup_seed15", lockedA, 0);
        sendGen(1);
        checkOutput("lockup_then_lock", lockedA, 1);
        sendGen(20);
        checkOutput("lockup_no_errors", errCountA, 0);

        // Gapped valid
        lockFresh();
        validCount = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                genBit(b);
                applyStimulus(1'b0, 1'b1, b, 1'b0);
                validCount++;
            end else begin
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        checkOutput("gaps_bit_count", bitCountA, validCount);
        checkOutput("gaps_err_count", errCountA, 0);

        // Clear coinciding with good and bad bits
        genBit(b);
        applyStimulus(1'b0, 1'b1, b, 1'b1);
        checkOutput("clear_good_err", errCountA, 0);
        checkOutput("clear_good_bits", bitCountA, 1);
        genBit(b);
        applyStimulus(1'b0, 1'b1, ~b, 1'b1);
        checkOutput("clear_bad_err", errCountA, 1);
        checkOutput("clear_bad_bits", bitCountA, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_idle_err", errCountA, 0);
        checkOutput("clear_idle_bits", bitCountA, 0);
        checkOutput("clear_keeps_lock", lockedA, 1);

        // Reset mid-CHECK
        sendGen(5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("midreset_locked", lockedA, 0);
        checkOutput("midreset_err", errCountA, 0);
        checkOutput("midreset_bits", bitCountA, 0);
        checkOutput("midreset_pulse", errPulseA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        chkEn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
